// File: rtl/axi_burst_tracker_if.sv
// Interface bundling the descriptor request channel and the beat output
// channel of axi_burst_tracker. The slave modport is the tracker's view;
// the master modport is the view of whatever issues descriptors and
// consumes beats.
interface axi_burst_tracker_if #(
  parameter int AW = 32
);
  logic          i_req_valid;
  logic          o_req_ready;
  logic [AW-1:0] i_req_addr;
  logic [7:0]    i_req_len;
  logic [2:0]    i_req_size;
  logic [1:0]    i_req_burst;
  logic          o_beat_valid;
  logic          i_beat_ready;
  logic [AW-1:0] o_beat_addr;
  logic [7:0]    o_beat_idx;
  logic          o_beat_last;
  logic          o_busy;
  logic          o_err;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_len, i_req_size, i_req_burst,
    input  i_beat_ready,
    output o_req_ready, o_beat_valid, o_beat_addr, o_beat_idx, o_beat_last,
    output o_busy, o_err
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_len, i_req_size, i_req_burst,
    output i_beat_ready,
    input  o_req_ready, o_beat_valid, o_beat_addr, o_beat_idx, o_beat_last,
    input  o_busy, o_err
  );
endinterface

// File: rtl/axi_burst_tracker.sv
// axi_burst_tracker: responder-side AXI AR/AW burst address generator.
// Takes one burst descriptor per request handshake and walks it out as one
// beat (address, index, last) per cycle, following the AXI next-address
// rules for FIXED, INCR and WRAP bursts with the 4KB page held constant.
// Optional descriptor checking is compiled in when AXI_BURST_CHECK_EN is
// defined; without it o_err is tied low and no check logic exists.
module axi_burst_tracker #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  axi_burst_tracker_if.slave   bus
);

  // Bus width must be a power of two between 8 and 1024 bits.
  if ((DW < 8) || (DW > 1024) || ((DW & (DW - 1)) != 0)) begin : g_dw_illegal
    $error("axi_burst_tracker: DW must be a power of 2 in 8..1024");
  end

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Bits below the 4KB page boundary are free to change; the rest are held.
  // For narrow address buses every bit is free.
  localparam logic [AW-1:0] PAGE_OFS_MASK = (AW > 12) ? AW'(12'hFFF) : {AW{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [AW-1:0] r_addr;
  logic [7:0]    r_idx;
  logic [7:0]    r_len;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;

  logic          w_req_fire;
  logic          w_beat_fire;
  logic          w_is_last;
  logic          w_wrap_len_ok;

  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_size_mask;
  logic [AW-1:0] w_aligned;
  logic [AW-1:0] w_wrap_mask;
  logic [AW-1:0] w_calc;
  logic [AW-1:0] w_next_addr;

  assign w_req_fire  = (r_state == ST_IDLE)  && bus.i_req_valid;
  assign w_beat_fire = (r_state == ST_BURST) && bus.i_beat_ready;
  assign w_is_last   = (r_idx == r_len);

  // ---------------------------------------------------------------------
  // Next-address arithmetic on the currently held beat address.
  // ---------------------------------------------------------------------
  assign w_inc         = AW'(1) << r_size;
  assign w_size_mask   = w_inc - AW'(1);
  // Adding the increment and then clearing the low bits aligns unaligned
  // start addresses from the second beat onwards.
  assign w_aligned     = (r_addr + w_inc) & ~w_size_mask;
  assign w_wrap_len_ok = (r_len == 8'd1) || (r_len == 8'd3) ||
                         (r_len == 8'd7) || (r_len == 8'd15);
  // Wrap window covers the whole burst; an illegal wrap length degenerates
  // to an empty window, which makes the address hold.
  assign w_wrap_mask   = w_wrap_len_ok ?
                         (((AW'(r_len) + AW'(1)) << r_size) - AW'(1)) : '0;

  // Select the raw next address by burst type (reserved type holds).
  always_comb begin
    w_calc = r_addr;
    case (r_burst)
      BURST_FIXED: w_calc = r_addr;
      BURST_INCR:  w_calc = w_aligned;
      BURST_WRAP:  w_calc = (r_addr & ~w_wrap_mask) | (w_aligned & w_wrap_mask);
      default:     w_calc = r_addr;
    endcase
  end

  // Page bits come from the current address, so any carry out of bit 11
  // is dropped and the burst never leaves its 4KB page.
  assign w_next_addr = (w_calc & PAGE_OFS_MASK) | (r_addr & ~PAGE_OFS_MASK);

  // ---------------------------------------------------------------------
  // Control FSM.
  // ---------------------------------------------------------------------

  // State register; reset aborts any burst immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: accept in IDLE, return to IDLE once the last beat is taken.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          w_state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (bus.i_beat_ready && w_is_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Descriptor capture and beat advance; values hold under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (w_req_fire) begin
      r_addr  <= bus.i_req_addr;
      r_idx   <= '0;
      r_len   <= bus.i_req_len;
      r_size  <= bus.i_req_size;
      r_burst <= bus.i_req_burst;
    end else if (w_beat_fire && !w_is_last) begin
      r_addr  <= w_next_addr;
      r_idx   <= r_idx + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Optional descriptor checking.
  // ---------------------------------------------------------------------
`ifdef AXI_BURST_CHECK_EN
  localparam int         MAXSZ   = $clog2(DW / 8);
  localparam logic [3:0] MAXSZ_L = 4'(MAXSZ);

  logic          r_err;
  logic          w_chk_err;
  logic          w_chk_wrap_len_ok;
  logic [AW-1:0] w_chk_size_mask;
  logic [AW-1:0] w_chk_end;

  assign w_chk_wrap_len_ok = (bus.i_req_len == 8'd1) || (bus.i_req_len == 8'd3) ||
                             (bus.i_req_len == 8'd7) || (bus.i_req_len == 8'd15);
  assign w_chk_size_mask   = (AW'(1) << bus.i_req_size) - AW'(1);
  // Address of the final byte an INCR burst would touch.
  assign w_chk_end         = bus.i_req_addr +
                             ((AW'(bus.i_req_len) + AW'(1)) << bus.i_req_size) - AW'(1);

  // Combine all descriptor violations; page compare is vacuous for AW<=12.
  always_comb begin
    w_chk_err = 1'b0;
    if (bus.i_req_burst == 2'b11) begin
      w_chk_err = 1'b1;
    end
    if ((bus.i_req_burst == BURST_WRAP) && !w_chk_wrap_len_ok) begin
      w_chk_err = 1'b1;
    end
    if ((bus.i_req_burst == BURST_WRAP) &&
        ((bus.i_req_addr & w_chk_size_mask) != '0)) begin
      w_chk_err = 1'b1;
    end
    if ({1'b0, bus.i_req_size} > MAXSZ_L) begin
      w_chk_err = 1'b1;
    end
    if ((bus.i_req_burst == BURST_INCR) &&
        ((bus.i_req_addr >> 12) != (w_chk_end >> 12))) begin
      w_chk_err = 1'b1;
    end
  end

  // Error flag captured at acceptance, held for the burst, cleared at its end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_req_fire) begin
      r_err <= w_chk_err;
    end else if (w_beat_fire && w_is_last) begin
      r_err <= 1'b0;
    end
  end

  assign bus.o_err = r_err;
`else
  assign bus.o_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------
  assign bus.o_req_ready  = (r_state == ST_IDLE);
  assign bus.o_beat_valid = (r_state == ST_BURST);
  assign bus.o_busy       = (r_state == ST_BURST);
  assign bus.o_beat_addr  = r_addr;
  assign bus.o_beat_idx   = r_idx;
  assign bus.o_beat_last  = (r_state == ST_BURST) && w_is_last;

endmodule

// File: tb/tb_axi_burst_tracker.sv
// Self-checking bench for axi_burst_tracker (AW=32, DW=32): directed
// scenarios plus randomized bursts checked against a closed-form model of
// the beat address sequence.
module tb_axi_burst_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_burst_tracker_if #(.AW(32)) bus ();

  axi_burst_tracker #(.AW(32), .DW(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from the most recent run_burst
  logic [31:0] q_addr[$];
  int          q_idx[$];
  bit          q_last[$];
  bit          q_err[$];
  bit          obs_first_valid, obs_ready_after, obs_busy_after, obs_err_after, obs_timeout;

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Reference: address of beat k, computed directly from the burst rules.
  function automatic logic [31:0] ref_addr(input logic [31:0] start, input int l,
                                           input int s, input int b, input int k);
    logic [31:0] inc, al, total, base;
    if (k == 0) return start;
    inc = 32'd1 << s;
    al  = start & ~(inc - 32'd1);
    if (b == 1) return {start[31:12], 12'(al + 32'(k) * inc)};
    if (b == 2 && (l == 1 || l == 3 || l == 7 || l == 15)) begin
      total = 32'(l + 1) * inc;
      base  = start & ~(total - 32'd1);
      return base + ((al - base + 32'(k) * inc) % total);
    end
    return start;
  endfunction

  // Reference: descriptor violation flag.
  function automatic bit ref_err(input logic [31:0] a, input int l, input int s, input int b);
    logic [31:0] last_byte;
    if (b == 3) return 1'b1;
    if (b == 2 && !(l == 1 || l == 3 || l == 7 || l == 15)) return 1'b1;
    if (b == 2 && (a % (32'd1 << s)) != 0) return 1'b1;
    if (s > 2) return 1'b1;
    last_byte = a + 32'(l + 1) * (32'd1 << s) - 32'd1;
    if (b == 1 && a[31:12] != last_byte[31:12]) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one descriptor and collect every accepted beat (no comparisons here).
  task automatic run_burst(input logic [31:0] a, input int l, input int s, input int b,
                           input int stall_pct);
    int  cnt;
    bit  done;
    q_addr.delete(); q_idx.delete(); q_last.delete(); q_err.delete();
    obs_timeout = 1'b0;
    cnt = 0;
    while (!bus.o_req_ready && cnt < 100) begin sync(); cnt++; end
    if (!bus.o_req_ready) obs_timeout = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = a;
    bus.i_req_len   = 8'(l);
    bus.i_req_size  = 3'(s);
    bus.i_req_burst = 2'(b);
    sync();
    bus.i_req_valid = 1'b0;
    obs_first_valid = bus.o_beat_valid;
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 2000) begin
      bus.i_beat_ready = ($urandom_range(99) >= stall_pct);
      if (bus.o_beat_valid && bus.i_beat_ready) begin
        q_addr.push_back(bus.o_beat_addr);
        q_idx.push_back(int'(bus.o_beat_idx));
        q_last.push_back(bus.o_beat_last);
        q_err.push_back(bus.o_err);
        if (bus.o_beat_last) done = 1'b1;
      end
      sync();
      cnt++;
    end
    bus.i_beat_ready = 1'b1;
    if (!done) obs_timeout = 1'b1;
    obs_ready_after = bus.o_req_ready;
    obs_busy_after  = bus.o_busy;
    obs_err_after   = bus.o_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_req_len = '0;
    bus.i_req_size = '0; bus.i_req_burst = '0; bus.i_beat_ready = 1'b1;
    #3;
    n_checks++;
    if ({bus.o_beat_valid, bus.o_beat_last, bus.o_busy, bus.o_err, bus.o_req_ready} !== 5'b00001)
      $display("FAIL reset_flags got v%b l%b b%b e%b r%b exp v0 l0 b0 e0 r1", bus.o_beat_valid,
               bus.o_beat_last, bus.o_busy, bus.o_err, bus.o_req_ready);
    else n_pass++;
    n_checks++;
    if (bus.o_beat_addr !== 32'h0 || bus.o_beat_idx !== 8'h0)
      $display("FAIL reset_addr_idx got %h/%0d exp 0/0", bus.o_beat_addr, bus.o_beat_idx);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sync();
  endtask

  task automatic test_incr_cross();
    logic [31:0] exp_a[4];
    exp_a = '{32'h0FF9, 32'h0FFC, 32'h0000, 32'h0004};
    run_burst(32'h0FF9, 3, 2, 1, 0);
    n_checks++;
    if (obs_timeout || q_addr.size() != 4)
      $display("FAIL incr_count got %0d beats (timeout %0b) exp 4", q_addr.size(), obs_timeout);
    else n_pass++;
    n_checks++;
    if (obs_first_valid !== 1'b1)
      $display("FAIL incr_latency got valid %b exp 1", obs_first_valid);
    else n_pass++;
    for (int k = 0; k < q_addr.size() && k < 4; k++) begin
      n_checks++;
      if (q_addr[k] !== exp_a[k] || q_idx[k] != k || q_last[k] != (k == 3))
        $display("FAIL incr_beat%0d got %h/%0d/%b exp %h/%0d/%b", k, q_addr[k], q_idx[k],
                 q_last[k], exp_a[k], k, (k == 3));
      else n_pass++;
    end
    n_checks++;
    if (obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0)
      $display("FAIL incr_ready_after got r%b b%b exp r1 b0", obs_ready_after, obs_busy_after);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a[4];
    exp_a = '{32'h1034, 32'h1038, 32'h103C, 32'h1030};
    run_burst(32'h1034, 3, 2, 2, 0);
    n_checks++;
    if (obs_timeout || q_addr.size() != 4)
      $display("FAIL wrap_count got %0d exp 4", q_addr.size());
    else n_pass++;
    for (int k = 0; k < q_addr.size() && k < 4; k++) begin
      n_checks++;
      if (q_addr[k] !== exp_a[k] || q_err[k] !== 1'b0 || q_last[k] != (k == 3))
        $display("FAIL wrap_beat%0d got %h err%b last%b exp %h err0 last%b", k, q_addr[k],
                 q_err[k], q_last[k], exp_a[k], (k == 3));
      else n_pass++;
    end
  endtask

  task automatic test_fixed();
    run_burst(32'h2000, 2, 2, 0, 0);
    n_checks++;
    if (obs_timeout || q_addr.size() != 3)
      $display("FAIL fixed_count got %0d exp 3", q_addr.size());
    else n_pass++;
    for (int k = 0; k < q_addr.size() && k < 3; k++) begin
      n_checks++;
      if (q_addr[k] !== 32'h2000 || q_last[k] != (k == 2) || q_idx[k] != k)
        $display("FAIL fixed_beat%0d got %h/%0d/%b exp 2000/%0d/%b", k, q_addr[k], q_idx[k],
                 q_last[k], k, (k == 2));
      else n_pass++;
    end
    run_burst(32'h2000, 0, 2, 0, 0);
    n_checks++;
    if (obs_timeout || q_addr.size() != 1 || q_last[0] !== 1'b1 || q_idx[0] != 0)
      $display("FAIL len0_single got %0d beats last%b exp 1 beat last1", q_addr.size(),
               (q_addr.size() > 0) ? q_last[0] : 1'b0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.i_beat_ready = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h100; bus.i_req_len = 8'd3;
    bus.i_req_size = 3'd2; bus.i_req_burst = 2'b01;
    sync();
    bus.i_req_valid = 1'b0;
    n_checks++;
    if (bus.o_beat_valid !== 1'b1 || bus.o_beat_addr !== 32'h100)
      $display("FAIL bp_beat0 got v%b %h exp v1 00000100", bus.o_beat_valid, bus.o_beat_addr);
    else n_pass++;
    sync();
    bus.i_beat_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.o_beat_addr !== 32'h104 || bus.o_beat_idx !== 8'd1 || bus.o_beat_valid !== 1'b1 ||
          bus.o_req_ready !== 1'b0 || bus.o_beat_last !== 1'b0)
        $display("FAIL bp_hold%0d got %h/%0d v%b r%b exp 00000104/1 v1 r0", i, bus.o_beat_addr,
                 bus.o_beat_idx, bus.o_beat_valid, bus.o_req_ready);
      else n_pass++;
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = $urandom;
      sync();
    end
    bus.i_req_valid = 1'b0;
    n_checks++;
    if (bus.o_beat_addr !== 32'h104 || bus.o_beat_idx !== 8'd1)
      $display("FAIL bp_after_stall got %h/%0d exp 00000104/1", bus.o_beat_addr, bus.o_beat_idx);
    else n_pass++;
    bus.i_beat_ready = 1'b1;
    sync();
    n_checks++;
    if (bus.o_beat_addr !== 32'h108 || bus.o_beat_idx !== 8'd2)
      $display("FAIL bp_resume2 got %h/%0d exp 00000108/2", bus.o_beat_addr, bus.o_beat_idx);
    else n_pass++;
    sync();
    n_checks++;
    if (bus.o_beat_addr !== 32'h10C || bus.o_beat_last !== 1'b1)
      $display("FAIL bp_resume3 got %h last%b exp 0000010c last1", bus.o_beat_addr, bus.o_beat_last);
    else n_pass++;
    sync();
    n_checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_beat_valid !== 1'b0)
      $display("FAIL bp_idle got r%b v%b exp r1 v0", bus.o_req_ready, bus.o_beat_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    bus.i_beat_ready = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h200; bus.i_req_len = 8'd7;
    bus.i_req_size = 3'd2; bus.i_req_burst = 2'b01;
    sync();
    bus.i_req_valid = 1'b0;
    sync();
    sync();
    n_checks++;
    if (bus.o_beat_idx !== 8'd2 || bus.o_beat_addr !== 32'h208)
      $display("FAIL rst_pre got %h/%0d exp 00000208/2", bus.o_beat_addr, bus.o_beat_idx);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_beat_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_req_ready !== 1'b1)
      $display("FAIL rst_abort got v%b b%b r%b exp v0 b0 r1", bus.o_beat_valid, bus.o_busy,
               bus.o_req_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      sync();
      n_checks++;
      if (bus.o_beat_valid !== 1'b0)
        $display("FAIL rst_hold%0d got v%b exp v0", i, bus.o_beat_valid);
      else n_pass++;
    end
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h40; bus.i_req_len = 8'd0;
    rst_n = 1'b1;
    sync();
    bus.i_req_valid = 1'b0;
    n_checks++;
    if (bus.o_beat_valid !== 1'b1 || bus.o_beat_addr !== 32'h40 || bus.o_beat_last !== 1'b1 ||
        bus.o_beat_idx !== 8'd0)
      $display("FAIL rst_new_req got v%b %h last%b idx%0d exp v1 00000040 last1 idx0",
               bus.o_beat_valid, bus.o_beat_addr, bus.o_beat_last, bus.o_beat_idx);
    else n_pass++;
    sync();
    n_checks++;
    if (bus.o_beat_valid !== 1'b0 || bus.o_req_ready !== 1'b1)
      $display("FAIL rst_new_done got v%b r%b exp v0 r1", bus.o_beat_valid, bus.o_req_ready);
    else n_pass++;
  endtask

`ifdef AXI_BURST_CHECK_EN
  task automatic test_err();
    run_burst(32'h1000, 2, 2, 2, 0);
    n_checks++;
    if (q_err.size() != 3 || q_err[0] !== 1'b1 || q_err[2] !== 1'b1 || obs_err_after !== 1'b0)
      $display("FAIL err_wrap_len got %0d beats err0 %b after %b exp 3 beats err 1 after 0",
               q_err.size(), (q_err.size() > 0) ? q_err[0] : 1'b0, obs_err_after);
    else n_pass++;
    run_burst(32'h3004, 1, 2, 3, 0);
    n_checks++;
    if (q_addr.size() != 2 || q_addr[0] !== 32'h3004 || q_addr[1] !== 32'h3004 ||
        q_err[1] !== 1'b1 || obs_err_after !== 1'b0)
      $display("FAIL err_rsvd got %0d beats addr1 %h err %b exp 2 beats 00003004 err 1",
               q_addr.size(), (q_addr.size() > 1) ? q_addr[1] : 32'h0,
               (q_err.size() > 1) ? q_err[1] : 1'b0);
    else n_pass++;
    run_burst(32'h100, 3, 2, 1, 0);
    n_checks++;
    if (q_err.size() != 4 || q_err[0] !== 1'b0)
      $display("FAIL err_legal got err %b exp 0", (q_err.size() > 0) ? q_err[0] : 1'b1);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] a, exp_a;
    int l, s, b;
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      l = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(15));
      s = ($urandom_range(7) == 0) ? int'($urandom_range(7)) : int'($urandom_range(2));
      b = int'($urandom_range(3));
      run_burst(a, l, s, b, 30);
      n_checks++;
      if (obs_timeout || q_addr.size() != l + 1)
        $display("FAIL rnd%0d_count got %0d exp %0d", t, q_addr.size(), l + 1);
      else n_pass++;
      for (int k = 0; k < q_addr.size() && k <= l; k++) begin
        exp_a = ref_addr(a, l, s, b, k);
        n_checks++;
        if (q_addr[k] !== exp_a || q_idx[k] != k || q_last[k] != (k == l))
          $display("FAIL rnd%0d_beat%0d a=%h l=%0d s=%0d b=%0d got %h/%0d/%b exp %h/%0d/%b", t, k,
                   a, l, s, b, q_addr[k], q_idx[k], q_last[k], exp_a, k, (k == l));
        else n_pass++;
      end
`ifdef AXI_BURST_CHECK_EN
      n_checks++;
      if (q_err.size() == 0 || q_err[0] !== ref_err(a, l, s, b) || obs_err_after !== 1'b0)
        $display("FAIL rnd%0d_err a=%h l=%0d s=%0d b=%0d got %b exp %b", t, a, l, s, b,
                 (q_err.size() > 0) ? q_err[0] : 1'b0, ref_err(a, l, s, b));
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_incr_cross();
    test_wrap();
    test_fixed();
    test_backpressure();
    test_reset_midburst();
`ifdef AXI_BURST_CHECK_EN
    test_err();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
